// File: rtl/regfile_write_scheduler_pkg.sv
// Shared CPU definitions for the register-file write scheduler: register
// widths and the pending-write entry carried by its replay queue.
package cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } pend_entry_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback-side bundle of the write scheduler: D/A write requests, operand
// read addresses, both register-file write ports, and status/forwarding.
interface regfile_write_scheduler_if;
    import cpu_pkg::*;

    logic                  d_write;
    logic [REG_ADDR_W-1:0] d_addr;
    logic [REG_DATA_W-1:0] d_data;
    logic                  a_write;
    logic [REG_ADDR_W-1:0] a_addr;
    logic [REG_DATA_W-1:0] a_data;
    logic [REG_ADDR_W-1:0] rd1_addr;
    logic [REG_ADDR_W-1:0] rd2_addr;

    logic                  reg3_write;
    logic [REG_ADDR_W-1:0] reg3_addr;
    logic [REG_DATA_W-1:0] reg3_bus;
    logic                  reg4_write;
    logic [REG_ADDR_W-1:0] reg4_addr;
    logic [REG_DATA_W-1:0] reg4_bus;
    logic                  stall;
    logic                  overflow;
    logic                  hazard1;
    logic                  hazard2;
    logic                  fwd1_valid;
    logic [REG_DATA_W-1:0] fwd1_data;
    logic                  fwd2_valid;
    logic [REG_DATA_W-1:0] fwd2_data;

    modport master (
        output d_write, d_addr, d_data, a_write, a_addr, a_data, rd1_addr, rd2_addr,
        input  reg3_write, reg3_addr, reg3_bus, reg4_write, reg4_addr, reg4_bus,
        input  stall, overflow, hazard1, hazard2,
        input  fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );

    modport slave (
        input  d_write, d_addr, d_data, a_write, a_addr, a_data, rd1_addr, rd2_addr,
        output reg3_write, reg3_addr, reg3_bus, reg4_write, reg4_addr, reg4_bus,
        output stall, overflow, hazard1, hazard2,
        output fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
    );

endinterface

// File: rtl/regfile_write_scheduler_match.sv
// wsched_match: hazard search of one read address over the pending queue.
// Youngest-match data search is built only when WSCHED_FORWARD_EN is defined.
module wsched_match
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  pend_entry_t           entries_i [DEPTH],
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  hit_o,
    output logic [REG_DATA_W-1:0] data_o
);

    // Entries arrive oldest first, so the last match in the scan is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_i[i].valid && (entries_i[i].addr == rd_addr_i)) begin
                hit_o = 1'b1;
`ifdef WSCHED_FORWARD_EN
                data_o = entries_i[i].data;
`endif
            end
        end
    end

`ifndef WSCHED_FORWARD_EN
    logic unusedData;
    always_comb begin
        unusedData = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unusedData = unusedData ^ (^entries_i[i].data);
        end
    end
`endif

endmodule

// File: rtl/regfile_write_scheduler.sv
// Write scheduler in front of register_file: D writes pass straight through, colliding
// A writes are queued and replayed on D-idle cycles. Forwarding gated by WSCHED_FORWARD_EN.
module regfile_write_scheduler
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    regfile_write_scheduler_if.slave  sched_io
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    pend_entry_t      queue_q [DEPTH];
    pend_entry_t      queue_d [DEPTH];
    pend_entry_t      ageOrdered [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             queueEmpty, queueFull, popHead, bypassA, enqReq, pushTail;
    logic             hit1, hit2;
    logic [REG_DATA_W-1:0] matchData1, matchData2;

    always_comb begin
        queueEmpty = (count_q == '0);
        queueFull  = (count_q == FULL_COUNT);
        popHead    = !sched_io.d_write && !queueEmpty;
        bypassA    = !sched_io.d_write && queueEmpty && sched_io.a_write;
        // A same-address D write in the same cycle is newer, so that A write is discarded.
        enqReq     = sched_io.a_write && !bypassA &&
                     !(sched_io.d_write && (sched_io.d_addr == sched_io.a_addr));
        pushTail   = enqReq && (!queueFull || popHead);
        overflow_d = overflow_q | (enqReq && queueFull && !popHead);

        queue_d = queue_q;
        if (sched_io.d_write) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (queue_q[i].addr == sched_io.d_addr) begin
                    queue_d[i].valid = 1'b0;
                end
            end
        end
        if (popHead) begin
            queue_d[head_q].valid = 1'b0;
        end
        if (pushTail) begin
            queue_d[tail_q] = '{valid: 1'b1, addr: sched_io.a_addr, data: sched_io.a_data};
        end

        head_d  = head_q + PTR_W'(popHead);
        tail_d  = tail_q + PTR_W'(pushTail);
        count_d = count_q + (PTR_W + 1)'(pushTail) - (PTR_W + 1)'(popHead);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            queue_q    <= queue_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ageOrdered[i] = queue_q[head_q + PTR_W'(i)];
        end
    end

    wsched_match #(.DEPTH(DEPTH)) u_match1 (
        .entries_i (ageOrdered),
        .rd_addr_i (sched_io.rd1_addr),
        .hit_o     (hit1),
        .data_o    (matchData1)
    );

    wsched_match #(.DEPTH(DEPTH)) u_match2 (
        .entries_i (ageOrdered),
        .rd_addr_i (sched_io.rd2_addr),
        .hit_o     (hit2),
        .data_o    (matchData2)
    );

    // The reg3 port stays a pure pass-through even while reset is asserted.
    always_comb begin
        sched_io.reg3_write = sched_io.d_write;
        sched_io.reg3_addr  = sched_io.d_addr;
        sched_io.reg3_bus   = sched_io.d_data;
        sched_io.reg4_write = 1'b0;
        sched_io.reg4_addr  = '0;
        sched_io.reg4_bus   = '0;
        if (rst_n) begin
            if (popHead) begin
                sched_io.reg4_write = queue_q[head_q].valid;
                sched_io.reg4_addr  = queue_q[head_q].addr;
                sched_io.reg4_bus   = queue_q[head_q].data;
            end else if (bypassA) begin
                sched_io.reg4_write = 1'b1;
                sched_io.reg4_addr  = sched_io.a_addr;
                sched_io.reg4_bus   = sched_io.a_data;
            end
        end
        sched_io.stall    = queueFull;
        sched_io.overflow = overflow_q;
        sched_io.hazard1  = hit1;
        sched_io.hazard2  = hit2;
`ifdef WSCHED_FORWARD_EN
        sched_io.fwd1_valid = hit1;
        sched_io.fwd2_valid = hit2;
`else
        sched_io.fwd1_valid = 1'b0;
        sched_io.fwd2_valid = 1'b0;
`endif
        sched_io.fwd1_data = matchData1;
        sched_io.fwd2_data = matchData2;
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_regfile_write_scheduler;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        bit        valid;
        bit [3:0]  addr;
        bit [15:0] data;
    } mEntry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_scheduler_if sched ();

    regfile_write_scheduler #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_io (sched)
    );

    mEntry_t pend[$];
    bit      overflowM;
    int      compareCount = 0;
    int      mismatchCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Predicts every output from the model queue and the inputs currently driven.
    task automatic checkAll();
        bit        e4w, e4Carry, h1, h2;
        bit [3:0]  e4a;
        bit [15:0] e4d, f1, f2;
        e4w = 0; e4Carry = 0; e4a = 0; e4d = 0; h1 = 0; h2 = 0; f1 = 0; f2 = 0;
        if (rst_n) begin
            if (!sched.d_write && pend.size() > 0) begin
                e4w = pend[0].valid; e4a = pend[0].addr; e4d = pend[0].data; e4Carry = 1;
            end else if (!sched.d_write && sched.a_write) begin
                e4w = 1; e4a = sched.a_addr; e4d = sched.a_data; e4Carry = 1;
            end
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].valid && pend[i].addr == sched.rd1_addr && !h1) begin h1 = 1; f1 = pend[i].data; end
                if (pend[i].valid && pend[i].addr == sched.rd2_addr && !h2) begin h2 = 1; f2 = pend[i].data; end
            end
        end else begin
            e4Carry = 1;
        end
        checkOutput("reg3_write", 32'(sched.reg3_write), 32'(sched.d_write));
        checkOutput("reg3_addr", 32'(sched.reg3_addr), 32'(sched.d_addr));
        checkOutput("reg3_bus", 32'(sched.reg3_bus), 32'(sched.d_data));
        checkOutput("reg4_write", 32'(sched.reg4_write), 32'(e4w));
        if (e4Carry) begin
            checkOutput("reg4_addr", 32'(sched.reg4_addr), 32'(e4a));
            checkOutput("reg4_bus", 32'(sched.reg4_bus), 32'(e4d));
        end
        checkOutput("stall", 32'(sched.stall), 32'(rst_n && pend.size() == DEPTH));
        checkOutput("overflow", 32'(sched.overflow), 32'(overflowM));
        checkOutput("hazard1", 32'(sched.hazard1), 32'(h1));
        checkOutput("hazard2", 32'(sched.hazard2), 32'(h2));
`ifdef WSCHED_FORWARD_EN
        checkOutput("fwd1_valid", 32'(sched.fwd1_valid), 32'(h1));
        checkOutput("fwd1_data", 32'(sched.fwd1_data), 32'(f1));
        checkOutput("fwd2_valid", 32'(sched.fwd2_valid), 32'(h2));
        checkOutput("fwd2_data", 32'(sched.fwd2_data), 32'(f2));
`else
        checkOutput("fwd1_valid", 32'(sched.fwd1_valid), 32'd0);
        checkOutput("fwd1_data", 32'(sched.fwd1_data), 32'd0);
        checkOutput("fwd2_valid", 32'(sched.fwd2_valid), 32'd0);
        checkOutput("fwd2_data", 32'(sched.fwd2_data), 32'd0);
`endif
    endtask

    // Applies this cycle's rising-edge effect to the model.
    task automatic updateModel();
        bit popped;
        popped = 0;
        if (!rst_n) return;
        if (sched.d_write) begin
            foreach (pend[i]) if (pend[i].addr == sched.d_addr) pend[i].valid = 0;
        end
        if (!sched.d_write && pend.size() > 0) begin
            void'(pend.pop_front());
            popped = 1;
        end
        if (sched.a_write) begin
            if (!sched.d_write && !popped) begin
                // bypassed straight to reg4
            end else if (sched.d_write && sched.d_addr == sched.a_addr) begin
                // discarded: the D write is newer
            end else if (pend.size() < DEPTH) begin
                pend.push_back('{valid: 1, addr: sched.a_addr, data: sched.a_data});
            end else begin
                overflowM = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit dW, input bit [3:0] dA, input bit [15:0] dD,
                                 input bit aW, input bit [3:0] aA, input bit [15:0] aD,
                                 input bit [3:0] r1, input bit [3:0] r2);
        sched.d_write = dW; sched.d_addr = dA; sched.d_data = dD;
        sched.a_write = aW; sched.a_addr = aA; sched.a_data = aD;
        sched.rd1_addr = r1; sched.rd2_addr = r2;
        #1;
        checkAll();
    endtask

    task automatic endCycle();
        updateModel();
        @(negedge clk);
    endtask

    task automatic cycle(input bit dW, input bit [3:0] dA, input bit [15:0] dD,
                         input bit aW, input bit [3:0] aA, input bit [15:0] aD);
        applyStimulus(dW, dA, dD, aW, aA, aD, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        endCycle();
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        pend.delete();
        overflowM = 0;
        repeat (n) begin
            cycle(1'($urandom), 4'($urandom), 16'($urandom), 1'b1, 4'($urandom), 16'($urandom));
        end
        rst_n = 1'b1;
    endtask

    initial begin
        sched.d_write = 0; sched.d_addr = 0; sched.d_data = 0;
        sched.a_write = 0; sched.a_addr = 0; sched.a_data = 0;
        sched.rd1_addr = 0; sched.rd2_addr = 0;
        @(negedge clk);
        doReset(2);

        // Uncontended A write bypasses in the same cycle.
        applyStimulus(0, 0, 0, 1, 5, 16'h1234, 5, 0);
        checkOutput("bypass_write", 32'(sched.reg4_write), 32'd1);
        checkOutput("bypass_addr", 32'(sched.reg4_addr), 32'd5);
        checkOutput("bypass_bus", 32'(sched.reg4_bus), 32'h1234);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
        checkOutput("bypass_noqueue", 32'(sched.hazard1), 32'd0);
        endCycle();

        // Colliding A write replays on the next idle cycle.
        cycle(1, 2, 16'hAAAA, 1, 7, 16'h0101);
        applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("replay_hazard", 32'(sched.hazard1), 32'd1);
        checkOutput("replay_write", 32'(sched.reg4_write), 32'd1);
        checkOutput("replay_addr", 32'(sched.reg4_addr), 32'd7);
        checkOutput("replay_bus", 32'(sched.reg4_bus), 32'h0101);
        endCycle();

        // A queued entry killed by a later D write to the same register.
        cycle(1, 0, 16'h5555, 1, 3, 16'h0001);
        cycle(1, 3, 16'hBEEF, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
        checkOutput("kill_write", 32'(sched.reg4_write), 32'd0);
        checkOutput("kill_hazard", 32'(sched.hazard1), 32'd0);
        endCycle();

        // Fill, overflow, and drain in order.
        doReset(1);
        for (int i = 1; i <= 4; i++) cycle(1, 0, 16'h0, 1, 4'(i), 16'(i * 16'h1111));
        applyStimulus(1, 0, 0, 1, 5, 16'h5555, 0, 0);
        checkOutput("full_stall", 32'(sched.stall), 32'd1);
        endCycle();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("drain_overflow", 32'(sched.overflow), 32'd1);
            checkOutput("drain_addr", 32'(sched.reg4_addr), 32'(i));
            checkOutput("drain_bus", 32'(sched.reg4_bus), 32'(i * 16'h1111));
            endCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drained_stall", 32'(sched.stall), 32'd0);
        endCycle();

        // Same-cycle D and A writes to one register: A discarded.
        doReset(1);
        applyStimulus(1, 9, 16'h9999, 1, 9, 16'h1111, 9, 0);
        checkOutput("same_reg4", 32'(sched.reg4_write), 32'd0);
        checkOutput("same_reg3", 32'(sched.reg3_addr), 32'd9);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 9);
        checkOutput("same_noqueue", 32'(sched.hazard1), 32'd0);
        checkOutput("same_idle", 32'(sched.reg4_write), 32'd0);
        endCycle();

        // Two queued writes to R6: forwarding picks the younger one.
        cycle(1, 0, 0, 1, 6, 16'h00FF);
        cycle(1, 0, 0, 1, 6, 16'h0F0F);
        applyStimulus(1, 0, 0, 0, 0, 0, 6, 1);
        checkOutput("fwd_hazard", 32'(sched.hazard1), 32'd1);
`ifdef WSCHED_FORWARD_EN
        checkOutput("fwd_valid", 32'(sched.fwd1_valid), 32'd1);
        checkOutput("fwd_data", 32'(sched.fwd1_data), 32'h0F0F);
`else
        checkOutput("fwd_valid", 32'(sched.fwd1_valid), 32'd0);
`endif
        endCycle();

        // Random traffic, including mid-queue resets.
        for (int n = 0; n < 2000; n++) begin
            bit dW, aW;
            if ($urandom_range(0, 249) == 0) doReset(1 + $urandom_range(0, 1));
            dW = ($urandom_range(0, 9) < 5);
            aW = ($urandom_range(0, 9) < 6);
            if (pend.size() == DEPTH && $urandom_range(0, 9) != 0) aW = 0;
            applyStimulus(dW, 4'($urandom_range(0, 7)), 16'($urandom), aW, 4'($urandom_range(0, 7)),
                          16'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
            endCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
